regfile_2w2r: RTL and testbench
===============================

Name: regfile_2w2r

Overview:
- Parametrised general-purpose register file for the CPU datapath.
- Two asynchronous read ports and two synchronous write ports, with a defined priority when both write ports hit the same address.
- A hardware clear sequencer fills every entry with a constant after reset or on request, so software never sees uninitialised registers.
- Sits between writeback (ports A and B) and operand fetch (read ports A and B).

Parameters:
- DW, 16, data width in bits.
- AW, 4, address width; depth = 2**AW entries.
- CLR_VAL, 0, DW-bit value written to every entry by the clear sequence.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  one-cycle pulse that starts a clear sequence.
- busy  out  1  high while the clear sequence runs.
- wea  in  1  write enable, port A.
- waddra  in  AW  write address, port A.
- dina  in  DW  write data, port A.
- web  in  1  write enable, port B.
- waddrb  in  AW  write address, port B.
- dinb  in  DW  write data, port B.
- raddra  in  AW  read address, port A.
- raddrb  in  AW  read address, port B.
- douta  out  DW  read data, port A.
- doutb  out  DW  read data, port B.

Behaviour:
- Storage: array of 2**AW words, DW bits each. No reset on the array itself; it is initialised only by the clear sequence.
- Clear FSM states:
  - IDLE: normal operation.
  - CLEAR: writes one address per cycle.
  - Counter cnt is AW bits wide.
- Reset behaviour (reset high at an edge):
  - state <= CLEAR, cnt <= 0, busy <= 1.
  - Reset takes priority over everything else.
  - Reset asserted mid-clear restarts the sequence at address 0.
- CLEAR state, each edge with reset low:
  - M[cnt] <= CLR_VAL, cnt <= cnt+1.
  - When cnt == 2**AW-1, that last write completes and the FSM returns to IDLE with busy <= 0.
  - busy is high for exactly 2**AW cycles after reset deasserts.
- clr pulse:
  - In IDLE: enter CLEAR with cnt <= 0, busy <= 1 on the next edge. Same timing as reset.
  - In CLEAR: restart cnt at 0.
- Writes during busy: wea and web are ignored (dropped, not queued).
- Writes in IDLE, on the rising edge:
  - wea=1: M[waddra] <= dina.
  - web=1: M[waddrb] <= dinb.
  - Both enabled with waddra == waddrb: port B wins; dina is discarded.
  - Different addresses: both writes complete in the same cycle.
- Reads:
  - Combinational, zero latency: douta = M[raddra], doutb = M[raddrb].
  - While busy = 1, douta and doutb are forced to 0 regardless of address.
  - A read of an address being written in the same cycle returns the old contents unless the optional feature below is compiled in.
  - Both read ports may address the same entry.
- Output reset values:
  - busy = 1 after any reset edge.
  - douta = doutb = 0 while busy.
  - After busy falls, every entry reads CLR_VAL until written.
- Address arithmetic: cnt wraps modulo 2**AW. Terminal detection uses an explicit compare against all-ones, not carry-out.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined — write-to-read forwarding:
  - In IDLE, if raddrX matches an enabled write address in the same cycle, doutX returns the incoming write data combinationally.
  - If both write ports match, dinb is forwarded (consistent with port-B priority).
  - No forwarding while busy; outputs stay 0.
- Not defined: reads return the pre-edge array contents; no forwarding muxes are synthesised.

Test Plan:
- Reset then clear timing: assert reset 1 cycle, then release.
  - busy is high for exactly 16 cycles, douta/doutb = 0 throughout.
  - After busy falls, reads of addresses 0..15 all return 0x0000.
- Dual write, distinct addresses: wea=1 waddra=3 dina=0x1234, web=1 waddrb=7 dinb=0xBEEF, same cycle.
  - Next cycle raddra=3 -> 0x1234, raddrb=7 -> 0xBEEF.
- Write collision: wea=web=1, both addresses 5, dina=0xAAAA, dinb=0x5555.
  - raddra=5 -> 0x5555.
- Bypass check: M[9]=0x0001, then same cycle wea=1 waddra=9 dina=0x0F0F with raddra=9.
  - With REGFILE_BYPASS_EN: douta = 0x0F0F that cycle.
  - Without: douta = 0x0001 that cycle, 0x0F0F next cycle.
- clr mid-operation: fill the array, pulse clr in IDLE, then pulse clr again at cycle 8 of the sequence.
  - busy is high for 8+16 cycles total.
  - wea=1 waddra=2 dina=0xFFFF issued during busy is dropped.
  - Final reads all 0x0000.
- Reset mid-clear: assert reset at cycle 10 of a clear.
  - cnt restarts; busy stays high for 16 more cycles after reset releases.
  - All entries read CLR_VAL afterwards.

Source files
------------

// File: rtl/regfile_2w2r.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_2w2r
//  Purpose  : General-purpose register file, 2 synchronous write ports and
//             2 asynchronous read ports. A hardware clear sequencer writes
//             CLR_VAL into every entry, one per cycle, after reset or on a
//             clr pulse, so no uninitialised register is ever visible.
//
//  Ports    : clk            clock, rising edge
//             reset          synchronous, active-high reset (starts a clear)
//             clr            one-cycle pulse, starts/restarts a clear
//             busy           high while the clear sequence runs
//             wea/waddra/dina  write port A
//             web/waddrb/dinb  write port B (wins over A on same address)
//             raddra/douta   read port A (combinational)
//             raddrb/doutb   read port B (combinational)
//
//  Options  : REGFILE_BYPASS_EN - when defined, a read of an address being
//             written in the same cycle returns the incoming write data.
//
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_2w2r #(
    parameter int            DW      = 16,
    parameter int            AW      = 4,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic          busy,
    input  logic          wea,
    input  logic [AW-1:0] waddra,
    input  logic [DW-1:0] dina,
    input  logic          web,
    input  logic [AW-1:0] waddrb,
    input  logic [DW-1:0] dinb,
    input  logic [AW-1:0] raddra,
    input  logic [AW-1:0] raddrb,
    output logic [DW-1:0] douta,
    output logic [DW-1:0] doutb
);

    localparam int            c_DEPTH    = 1 << AW;
    localparam logic [AW-1:0] c_CNT_LAST = '1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            r_busy;
    logic            w_busy_nxt;

    // Storage carries no reset; it is initialised only by the clear sequence.
    logic [DW-1:0]   r_mem [0:c_DEPTH-1];

    logic            w_clr_we;
    logic            w_we_a;
    logic            w_we_b;
    logic [DW-1:0]   w_rd_a;
    logic [DW-1:0]   w_rd_b;

    // ------------------------------------------------------------------
    // Clear sequencer: state register (reset has top priority)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Clear sequencer: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (clr) begin
                    // Restart takes precedence over finishing the sweep.
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Array writes. User writes are dropped while clearing and on a
    // reset edge.
    // ------------------------------------------------------------------
    assign w_clr_we = (r_state == S_CLEAR) && !reset;
    assign w_we_a   = (r_state == S_IDLE) && !reset && wea;
    assign w_we_b   = (r_state == S_IDLE) && !reset && web;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= CLR_VAL;
        end else begin
            if (w_we_a) begin
                r_mem[waddra] <= dina;
            end
            // Port B is written last so it wins an address collision.
            if (w_we_b) begin
                r_mem[waddrb] <= dinb;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    always_comb begin
        w_rd_a = r_mem[raddra];
        if (web && (waddrb == raddra)) begin
            w_rd_a = dinb;
        end else if (wea && (waddra == raddra)) begin
            w_rd_a = dina;
        end
    end

    always_comb begin
        w_rd_b = r_mem[raddrb];
        if (web && (waddrb == raddrb)) begin
            w_rd_b = dinb;
        end else if (wea && (waddra == raddrb)) begin
            w_rd_b = dina;
        end
    end
`else
    assign w_rd_a = r_mem[raddra];
    assign w_rd_b = r_mem[raddrb];
`endif

    // Outputs are masked while clearing so partially cleared data never leaks.
    assign douta = r_busy ? '0 : w_rd_a;
    assign doutb = r_busy ? '0 : w_rd_b;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2w2r.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_2w2r
//  Purpose  : Self-checking bench for regfile_2w2r. A reference model keeps
//             the register contents as a plain array plus a count of clear
//             cycles still outstanding.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2w2r;

    localparam int          DW    = 16;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [15:0] CLRV  = 16'h0000;

    logic        clk = 1'b0;
    logic        reset, clr, busy;
    logic        wea, web;
    logic [3:0]  waddra, waddrb, raddra, raddrb;
    logic [15:0] dina, dinb, douta, doutb;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [15:0] model [DEPTH];
    int          left = 0;   // clear cycles still to run; busy while > 0

    regfile_2w2r #(.DW(DW), .AW(AW), .CLR_VAL(CLRV)) dut (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy),
        .wea(wea), .waddra(waddra), .dina(dina),
        .web(web), .waddrb(waddrb), .dinb(dinb),
        .raddra(raddra), .raddrb(raddrb),
        .douta(douta), .doutb(doutb)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_read(input logic [3:0] ra);
        if (left > 0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (web && waddrb == ra) return dinb;
        if (wea && waddra == ra) return dina;
`endif
        return model[ra];
    endfunction

    // Advance the model by one edge using current inputs, then clock the DUT.
    // A clear's end result is every entry at CLRV, and reads are masked
    // until then, so the model fills the array at the moment a clear starts.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) model[i] = CLRV;
            left = DEPTH;
        end else if (left > 0) begin
            if (clr) left = DEPTH;
            else     left = left - 1;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) model[i] = CLRV;
            left = DEPTH;
        end else begin
            if (wea) model[waddra] = dina;
            if (web) model[waddrb] = dinb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clr = 1'b0; wea = 1'b0; web = 1'b0;
        waddra = '0; waddrb = '0; dina = '0; dinb = '0; raddra = '0; raddrb = '0;
        @(posedge clk); #1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", busy); end
        for (int i = 0; i < DEPTH; i++) begin
            raddra = 4'($urandom); raddrb = 4'($urandom);
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b1 || douta !== 16'h0 || doutb !== 16'h0) begin
                n_err++;
                $display("FAIL reset_clear_cyc%0d: busy=%b douta=%h doutb=%h expected 1/0000/0000", i, busy, douta, doutb);
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_fall: got %b expected 0", busy); end
        for (int a = 0; a < DEPTH; a++) begin
            raddra = 4'(a); raddrb = 4'(DEPTH - 1 - a);
            @(negedge clk);
            n_cmp++;
            if (douta !== CLRV || doutb !== CLRV) begin
                n_err++;
                $display("FAIL reset_readback[%0d]: douta=%h doutb=%h expected %h", a, douta, doutb, CLRV);
            end
            tick();
        end
    endtask

    task automatic test_dual_write();
        wea = 1'b1; waddra = 4'd3; dina = 16'h1234;
        web = 1'b1; waddrb = 4'd7; dinb = 16'hBEEF;
        tick();
        wea = 1'b0; web = 1'b0;
        raddra = 4'd3; raddrb = 4'd7;
        @(negedge clk);
        n_cmp++;
        if (douta !== 16'h1234) begin n_err++; $display("FAIL dual_write_a: got %h expected 1234", douta); end
        n_cmp++;
        if (doutb !== 16'hBEEF) begin n_err++; $display("FAIL dual_write_b: got %h expected beef", doutb); end
        tick();
    endtask

    task automatic test_collision();
        wea = 1'b1; waddra = 4'd5; dina = 16'hAAAA;
        web = 1'b1; waddrb = 4'd5; dinb = 16'h5555;
        tick();
        wea = 1'b0; web = 1'b0;
        raddra = 4'd5; raddrb = 4'd5;
        @(negedge clk);
        n_cmp++;
        if (douta !== 16'h5555 || doutb !== 16'h5555) begin
            n_err++;
            $display("FAIL collision: douta=%h doutb=%h expected 5555", douta, doutb);
        end
        tick();
    endtask

    task automatic test_bypass();
        logic [15:0] exp_now;
        wea = 1'b1; waddra = 4'd9; dina = 16'h0001;
        tick();
        wea = 1'b1; waddra = 4'd9; dina = 16'h0F0F; raddra = 4'd9;
`ifdef REGFILE_BYPASS_EN
        exp_now = 16'h0F0F;
`else
        exp_now = 16'h0001;
`endif
        @(negedge clk);
        n_cmp++;
        if (douta !== exp_now) begin n_err++; $display("FAIL bypass_same_cycle: got %h expected %h", douta, exp_now); end
        tick();
        wea = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (douta !== 16'h0F0F) begin n_err++; $display("FAIL bypass_next_cycle: got %h expected 0f0f", douta); end
        tick();
    endtask

    task automatic test_clr_restart();
        int busy_cnt = 0;
        for (int i = 0; i < DEPTH / 2; i++) begin
            wea = 1'b1; waddra = 4'(2 * i);     dina = 16'($urandom) | 16'h0100;
            web = 1'b1; waddrb = 4'(2 * i + 1); dinb = 16'($urandom) | 16'h0100;
            tick();
        end
        wea = 1'b0; web = 1'b0; raddra = 4'd2; raddrb = 4'd11;
        @(negedge clk);
        n_cmp++;
        if (douta !== ref_read(raddra) || doutb !== ref_read(raddrb)) begin
            n_err++;
            $display("FAIL fill_readback: douta=%h doutb=%h expected %h %h", douta, doutb, ref_read(raddra), ref_read(raddrb));
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            clr = (i == 7);
            wea = (left > 0); waddra = 4'd2; dina = 16'hFFFF;
            raddra = 4'd2; raddrb = 4'($urandom);
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            n_cmp++;
            if (busy !== (left > 0) || douta !== ref_read(raddra) || doutb !== ref_read(raddrb)) begin
                n_err++;
                $display("FAIL clr_cyc%0d: busy=%b douta=%h doutb=%h expected %b %h %h", i, busy, douta, doutb, left > 0, ref_read(raddra), ref_read(raddrb));
            end
            tick();
        end
        clr = 1'b0; wea = 1'b0;
        n_cmp++;
        if (busy_cnt != 24) begin n_err++; $display("FAIL clr_busy_len: got %0d expected 24", busy_cnt); end
        for (int a = 0; a < DEPTH; a++) begin
            raddra = 4'(a);
            @(negedge clk);
            n_cmp++;
            if (douta !== CLRV) begin n_err++; $display("FAIL clr_readback[%0d]: got %h expected %h", a, douta, CLRV); end
            tick();
        end
    endtask

    task automatic test_reset_mid_clear();
        int busy_cnt = 0;
        wea = 1'b1; waddra = 4'd4; dina = 16'h7777;
        tick();
        wea = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
        n_cmp++;
        if (busy_cnt != 16) begin n_err++; $display("FAIL reset_mid_clear_len: got %0d expected 16", busy_cnt); end
        for (int a = 0; a < DEPTH; a++) begin
            raddra = 4'(a); raddrb = 4'(a);
            @(negedge clk);
            n_cmp++;
            if (douta !== CLRV || doutb !== CLRV) begin
                n_err++;
                $display("FAIL reset_mid_clear_rd[%0d]: douta=%h doutb=%h expected %h", a, douta, doutb, CLRV);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            wea = 1'($urandom); web = 1'($urandom);
            // Narrow address range half the time to provoke collisions.
            waddra = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            waddrb = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            raddra = ($urandom_range(0, 1) == 0) ? waddra : 4'($urandom);
            raddrb = ($urandom_range(0, 1) == 0) ? waddrb : 4'($urandom);
            dina = 16'($urandom); dinb = 16'($urandom);
            clr = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            n_cmp++;
            if (busy !== (left > 0) || douta !== ref_read(raddra) || doutb !== ref_read(raddrb)) begin
                n_err++;
                $display("FAIL random_cyc%0d: busy=%b douta=%h doutb=%h expected %b %h %h", i, busy, douta, doutb, left > 0, ref_read(raddra), ref_read(raddrb));
            end
            tick();
        end
        wea = 1'b0; web = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_collision();
        test_bypass();
        test_clr_restart();
        test_reset_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
